seg_scan_driver: RTL

- Parametrised multiplexed seven-segment display driver for the board top level.
- Scans N_DIGITS hex digits onto a shared seg bus and a one-hot dig bus.
- Adds features the current fixed 4-digit driver lacks:
  - tear-free double-buffered value loading;
  - leading-zero blanking;
  - per-digit decimal points;
  - PWM brightness control;
  - selectable output polarity.
- Sits between the CPU's memory-mapped output register and the seg/dig pins.

---
 rtl/seg_scan_driver.sv | 103 ++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex seven-segment scanner with double-buffered load, zero blanking, PWM and polarity control
module seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int DIV_LOG2       = 16,
    parameter int BR_W           = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  blank_lz,
    input  logic                  en,
    input  logic [BR_W-1:0]       brightness,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   dig,
    output logic                  frame_tick
);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW}};

    logic [DIV_LOG2-1:0]   cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] pend_val, shad_val;
    logic [N_DIGITS-1:0]   pend_dp, shad_dp, blank, dig_on;
    logic                  pend_valid, slot_end, wrap, lit, zero_above;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [7:0]            seg_on;

    assign slot_end = &cnt;
    assign wrap     = slot_end && idx == IW'(N_DIGITS - 1);
    assign lit      = en && cnt[DIV_LOG2-1 -: BR_W] <= brightness;
    assign nib      = 4'(shad_val >> {idx, 2'b00});

    // a digit is blanked only when it and every more significant nibble are zero
    always_comb begin
        zero_above = 1'b1;
        blank = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && shad_val[4*k +: 4] == 4'h0;
            blank[k] = blank_lz && zero_above;
        end
    end

    // glyph bits are {g,f,e,d,c,b,a}, active-high
    always_comb
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase

    assign seg_on = lit && !blank[idx] ? {shad_dp[idx], glyph} : 8'h00;
    assign dig_on = lit ? N_DIGITS'(1) << idx : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            shad_val   <= '0;
            shad_dp    <= '0;
            pend_valid <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
            dig        <= DIG_OFF;
        end else begin
            cnt <= cnt + DIV_LOG2'(1);
            if (slot_end)
                idx <= wrap ? '0 : idx + IW'(1);
            frame_tick <= wrap;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            if (wrap && pend_valid) begin
                shad_val <= pend_val;
                shad_dp  <= pend_dp;
            end
            pend_valid <= load || (pend_valid && !wrap);
            // xor with the idle level flips polarity for active-low pins
            seg <= seg_on ^ SEG_OFF;
            dig <= dig_on ^ DIG_OFF;
        end
endmodule
